regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, 1, when 1 register 0 SHALL be hardwired to zero.
REQ-004 Parameter BYPASS, 1, when 1 the read ports SHALL forward same-cycle write data.
REQ-005 clk  in  1  single clock, all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 Aa  in  ADDR_W  read port A address.
REQ-008 Ab  in  ADDR_W  read port B address.
REQ-009 Aw  in  ADDR_W  write address.
REQ-010 Dw  in  WIDTH  write data.
REQ-011 WrEn  in  1  write enable.
REQ-012 WrBe  in  WIDTH/8  byte enables; bit i qualifies Dw[8i+7:8i].
REQ-013 Clr  in  1  request to start a clear sweep.
REQ-014 Da  out  WIDTH  read port A data.
REQ-015 Db  out  WIDTH  read port B data.
REQ-016 Busy  out  1  registered; high while a clear sweep is in progress.
REQ-017 ClrDone  out  1  registered one-cycle pulse at sweep completion.
REQ-018 WrDrop  out  1  registered one-cycle pulse when a write was rejected.

Function
REQ-019 Reads SHALL be combinational: Da = reg[Aa], Db = reg[Ab], with no clock latency.
REQ-020 With ZERO_REG=1, reads of address 0 SHALL return 0, and writes to address 0 SHALL be discarded without asserting WrDrop.
REQ-021 In IDLE, a write with WrEn=1 SHALL update reg[Aw] at the rising edge, byte i taken from Dw when WrBe[i]=1 and retained otherwise; WrBe=0 leaves the register unchanged.
REQ-022 With BYPASS=1, WrEn=1, state IDLE and Aa==Aw (Aw non-zero when ZERO_REG=1), Da SHALL equal the byte-merged write value in the same cycle; Db likewise for Ab.
REQ-023 With BYPASS=0, reads SHALL return the pre-edge stored value.
REQ-024 State machine SHALL have exactly the states IDLE and SWEEP.
REQ-025 IDLE->SWEEP SHALL occur when Clr=1 at an edge; index counter SHALL load 0.
REQ-026 In SWEEP, each edge SHALL clear reg[index] to 0 and increment index; at index==DEPTH-1 the FSM SHALL clear that entry and return to IDLE.
REQ-027 Busy SHALL be high for exactly DEPTH cycles per sweep, starting the cycle after Clr is sampled.
REQ-028 ClrDone SHALL pulse high for one cycle, the cycle after Busy falls.
REQ-029 Clr asserted while in SWEEP SHALL be ignored; it neither restarts nor extends the sweep.
REQ-030 WrEn=1 during SWEEP SHALL NOT modify storage, and WrDrop SHALL pulse the following cycle; bypass SHALL be inactive in SWEEP.
REQ-031 Clr=1 and WrEn=1 in the same IDLE cycle: the write SHALL commit at that edge, and the sweep SHALL then begin and clear it.
REQ-032 Reads during SWEEP SHALL return current storage: entries already swept read 0, and the remaining entries read their old values.

Reset
REQ-033 reset=1 at an edge SHALL zero all registers, force IDLE, set index=0, and drive Busy, ClrDone and WrDrop to 0.
REQ-034 reset SHALL take priority over Clr and WrEn in the same cycle.
REQ-035 reset during SWEEP SHALL abort the sweep without a ClrDone pulse.

Verification
REQ-036 Write Aw=2, Dw=42, WrBe=all-ones; next cycle Aa=Ab=2 -> Da=Db=42.
REQ-037 reg2=0x11223344; write WrBe=4'b0010, Dw=0xAABBCCDD -> reg2 reads 0x1122CC44; with BYPASS=1, Aa=2 shows 0x1122CC44 in the write cycle itself.
REQ-038 Write Aw=0, Dw=12 with ZERO_REG=1 -> Da=0 and WrDrop=0.
REQ-039 Fill all regs non-zero, then pulse Clr -> Busy high exactly 32 cycles, ClrDone pulses once after Busy falls, and all regs read 0.
REQ-040 WrEn=1, Aw=5 in sweep cycle 3 -> reg5 remains 0 after the sweep, and WrDrop pulses once.
REQ-041 reset asserted in sweep cycle 10 -> next cycle Busy=0, all regs read 0, and no ClrDone pulse.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised register file with two combinational read ports, one
// byte-enabled write port, optional hardwired-zero register 0, optional
// same-cycle write forwarding, and a sequential clear sweep engine.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    Aa,
  input  logic [ADDR_W-1:0]    Ab,
  input  logic [ADDR_W-1:0]    Aw,
  input  logic [WIDTH-1:0]     Dw,
  input  logic                 WrEn,
  input  logic [WIDTH/8-1:0]   WrBe,
  input  logic                 Clr,
  output logic [WIDTH-1:0]     Da,
  output logic [WIDTH-1:0]     Db,
  output logic                 Busy,
  output logic                 ClrDone,
  output logic                 WrDrop
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = WIDTH / 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [WIDTH-1:0]  merged;
  logic              wr_ok;
  logic              fwd_a;
  logic              fwd_b;

  // Write qualification and byte merge of new data over the stored word
  always_comb begin
    wr_ok  = (state == IDLE) && WrEn && !((ZERO_REG != 0) && (Aw == '0));
    merged = mem[Aw];
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (WrBe[i]) merged[8*i +: 8] = Dw[8*i +: 8];
    end
  end

  // Combinational read ports with optional forwarding of the merged write
  always_comb begin
    fwd_a = (BYPASS != 0) && wr_ok && (Aa == Aw);
    fwd_b = (BYPASS != 0) && wr_ok && (Ab == Aw);
    if ((ZERO_REG != 0) && (Aa == '0)) Da = '0;
    else if (fwd_a)                    Da = merged;
    else                               Da = mem[Aa];
    if ((ZERO_REG != 0) && (Ab == '0)) Db = '0;
    else if (fwd_b)                    Db = merged;
    else                               Db = mem[Ab];
  end

  // Storage update: reset clears everything, sweep clears one entry per edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == SWEEP) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      mem[Aw] <= merged;
    end
  end

  // Sweep FSM, index counter and registered status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      ClrDone <= 1'b0;
      WrDrop  <= 1'b0;
    end else begin
      ClrDone <= 1'b0;
      WrDrop  <= (state == SWEEP) && WrEn;
      case (state)
        IDLE: begin
          if (Clr) begin
            state <= SWEEP;
            idx   <= '0;
          end
        end
        SWEEP: begin
          if (idx == '1) begin
            state   <= IDLE;
            idx     <= '0;
            ClrDone <= 1'b1;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == SWEEP);

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (default parameters).
module tb_regfile_param;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] Aa, Ab, Aw;
  logic [WIDTH-1:0]  Dw;
  logic              WrEn;
  logic [3:0]        WrBe;
  logic              Clr;
  logic [WIDTH-1:0]  Da, Db;
  logic              Busy, ClrDone, WrDrop;

  int total  = 0;
  int passed = 0;

  regfile_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .Aa(Aa), .Ab(Ab), .Aw(Aw), .Dw(Dw),
    .WrEn(WrEn), .WrBe(WrBe), .Clr(Clr), .Da(Da), .Db(Db),
    .Busy(Busy), .ClrDone(ClrDone), .WrDrop(WrDrop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    WrEn = 1'b1; Aw = a; Dw = d; WrBe = 4'hF;
    tick();
    WrEn = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 1; i < DEPTH; i++) wr(ADDR_W'(i), 32'h0101_0101 * (i + 1));
  endtask

  task automatic test_reset();
    reset = 1'b1; WrEn = 1'b1; Clr = 1'b1; Aw = 5'd4; Dw = 32'hFFFF_FFFF; WrBe = 4'hF;
    Aa = 5'd4; Ab = 5'd9;
    tick();
    reset = 1'b0; WrEn = 1'b0; Clr = 1'b0;
    #1;
    total++;
    if (Busy !== 1'b0 || ClrDone !== 1'b0 || WrDrop !== 1'b0)
      $display("FAIL reset_flags: Busy=%b ClrDone=%b WrDrop=%b, want 000", Busy, ClrDone, WrDrop);
    else passed++;
    total++;
    if (Da !== 32'h0 || Db !== 32'h0)
      $display("FAIL reset_data: Da=%h Db=%h, want 0", Da, Db);
    else passed++;
  endtask

  task automatic test_write_read();
    wr(5'd2, 32'd42);
    Aa = 5'd2; Ab = 5'd2;
    #1;
    total++;
    if (Da !== 32'd42 || Db !== 32'd42)
      $display("FAIL write_read: Da=%0d Db=%0d, want 42", Da, Db);
    else passed++;
  endtask

  task automatic test_byte_enable();
    wr(5'd2, 32'h1122_3344);
    wr(5'd3, 32'h0000_0777);
    WrEn = 1'b1; Aw = 5'd2; Dw = 32'hAABB_CCDD; WrBe = 4'b0010; Aa = 5'd2; Ab = 5'd3;
    #1;
    total++;
    if (Da !== 32'h1122_CC44)
      $display("FAIL bypass_merge: Da=%h, want 1122cc44", Da);
    else passed++;
    total++;
    if (Db !== 32'h0000_0777)
      $display("FAIL bypass_other_addr: Db=%h, want 00000777", Db);
    else passed++;
    tick();
    WrEn = 1'b0;
    #1;
    total++;
    if (Da !== 32'h1122_CC44)
      $display("FAIL byte_en_stored: Da=%h, want 1122cc44", Da);
    else passed++;
    WrEn = 1'b1; Dw = 32'hFFFF_FFFF; WrBe = 4'b0000;
    tick();
    WrEn = 1'b0;
    #1;
    total++;
    if (Da !== 32'h1122_CC44)
      $display("FAIL byte_en_none: Da=%h, want 1122cc44", Da);
    else passed++;
  endtask

  task automatic test_zero_reg();
    WrEn = 1'b1; Aw = 5'd0; Dw = 32'd12; WrBe = 4'hF; Aa = 5'd0;
    #1;
    total++;
    if (Da !== 32'h0)
      $display("FAIL zero_reg_bypass: Da=%h, want 0", Da);
    else passed++;
    tick();
    WrEn = 1'b0;
    #1;
    total++;
    if (Da !== 32'h0 || WrDrop !== 1'b0)
      $display("FAIL zero_reg_write: Da=%h WrDrop=%b, want 0 0", Da, WrDrop);
    else passed++;
  endtask

  task automatic test_sweep();
    int cnt;
    int bad;
    fill_all();
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    cnt = 0; bad = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 4) Clr = 1'b1;
      if (cnt == 5) Clr = 1'b0;
      if (ClrDone !== 1'b0) bad++;
      if (cnt == 6) begin
        Aa = 5'd3; Ab = 5'd20;
        #1;
        total++;
        if (Da !== 32'h0 || Db !== 32'h1515_1515)
          $display("FAIL sweep_partial: Da=%h Db=%h, want 0 15151515", Da, Db);
        else passed++;
      end
      tick();
    end
    Clr = 1'b0;
    total++;
    if (cnt !== DEPTH)
      $display("FAIL sweep_busy_len: busy cycles=%0d, want %0d", cnt, DEPTH);
    else passed++;
    total++;
    if (bad !== 0 || ClrDone !== 1'b1)
      $display("FAIL sweep_done_pulse: early=%0d ClrDone=%b, want 0 1", bad, ClrDone);
    else passed++;
    tick();
    total++;
    if (ClrDone !== 1'b0 || Busy !== 1'b0)
      $display("FAIL sweep_done_single: ClrDone=%b Busy=%b, want 0 0", ClrDone, Busy);
    else passed++;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      Aa = ADDR_W'(i);
      #1;
      if (Da !== 32'h0) bad++;
    end
    total++;
    if (bad !== 0)
      $display("FAIL sweep_all_zero: nonzero regs=%0d, want 0", bad);
    else passed++;
  endtask

  task automatic test_sweep_write_drop();
    int cnt;
    int drops;
    wr(5'd5, 32'h0000_0055);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    cnt = 0; drops = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 3) begin
        WrEn = 1'b1; Aw = 5'd5; Dw = 32'hDEAD_BEEF; WrBe = 4'hF; Aa = 5'd5;
        #1;
        total++;
        if (Da !== 32'h0000_0055)
          $display("FAIL sweep_no_bypass: Da=%h, want 00000055", Da);
        else passed++;
      end
      tick();
      WrEn = 1'b0;
      if (WrDrop === 1'b1) drops++;
    end
    tick();
    if (WrDrop === 1'b1) drops++;
    total++;
    if (cnt !== DEPTH || drops !== 1)
      $display("FAIL wrdrop_pulse: busy=%0d drops=%0d, want %0d 1", cnt, drops, DEPTH);
    else passed++;
    Aa = 5'd5;
    #1;
    total++;
    if (Da !== 32'h0)
      $display("FAIL sweep_write_blocked: Da=%h, want 0", Da);
    else passed++;
  endtask

  task automatic test_clr_with_write();
    int cnt;
    Clr = 1'b1; WrEn = 1'b1; Aw = 5'd7; Dw = 32'd77; WrBe = 4'hF;
    tick();
    Clr = 1'b0; WrEn = 1'b0; Aa = 5'd7;
    #1;
    total++;
    if (Busy !== 1'b1 || Da !== 32'd77)
      $display("FAIL clr_write_commit: Busy=%b Da=%0d, want 1 77", Busy, Da);
    else passed++;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    total++;
    if (cnt !== DEPTH || Da !== 32'h0)
      $display("FAIL clr_write_cleared: busy=%0d Da=%0d, want %0d 0", cnt, Da, DEPTH);
    else passed++;
    tick();
  endtask

  task automatic test_reset_in_sweep();
    int cnt;
    int bad;
    fill_all();
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    cnt = 1;
    while (cnt < 10 && Busy === 1'b1) begin
      cnt++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (Busy !== 1'b0 || ClrDone !== 1'b0)
      $display("FAIL reset_abort: Busy=%b ClrDone=%b, want 0 0", Busy, ClrDone);
    else passed++;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      Aa = ADDR_W'(i);
      #1;
      if (Da !== 32'h0) bad++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ClrDone !== 1'b0 || Busy !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0)
      $display("FAIL reset_abort_state: bad=%0d, want 0", bad);
    else passed++;
  endtask

  initial begin
    reset = 1'b0; WrEn = 1'b0; Clr = 1'b0; WrBe = 4'h0;
    Aa = '0; Ab = '0; Aw = '0; Dw = '0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_zero_reg();
    test_sweep();
    test_sweep_write_drop();
    test_clr_with_write();
    test_reset_in_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
